fc_layer_seq: RTL
=================

// Module: fc_layer_seq
// PURPOSE
//  Generic sequential fully-connected NN layer: y[o] = act(sum_i x[i]*W[i][o] + b[o]).
//  Fetches x from an activation RAM and W/b from a weight ROM, one MAC per cycle.
//  Sits between consecutive layer stages in the inference pipeline and is chained
//  by start/done. Layer sizes, widths and fixed-point format are parameters.
// PARAMETERS
//  NUM_INPUTS   20  input vector length (>=1)
//  NUM_OUTPUTS  7   output units (>=1)
//  DATA_W       32  signed width of x, W, b, y
//  FRAC_W       16  fractional bits (Q format shared by x, W, b, y)
//  ACC_W        40  signed accumulator width (>= DATA_W)
//  IN_ADDR_W    5   activation RAM address width
//  W_ADDR_W     15  weight ROM address width
// PORTS
//  clk        in   1                      clock
//  reset      in   1                      synchronous, active-high
//  start      in   1                      level request; 4-phase with done
//  w_base     in   W_ADDR_W               ROM base of this layer; sampled when start is accepted
//  in_addr    out  IN_ADDR_W              activation RAM read address
//  in_data    in   DATA_W                 RAM data, valid 1 cycle after in_addr
//  w_addr     out  W_ADDR_W               weight ROM read address
//  w_data     in   DATA_W                 ROM data, valid 1 cycle after w_addr
//  busy       out  1                      high in every state except IDLE and DONE
//  done       out  1                      high in DONE
//  y_out      out  NUM_OUTPUTS*DATA_W     y[o] at bits [o*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset: state=IDLE; acc[*]=0, y_out=0, done=0, busy=0, in_addr=0, w_addr=0, counters=0.
//  FSM: IDLE -(start)-> CLEAR -> FETCH_X -> MAC -> {FETCH_X | BIAS} -> DONE -(!start)-> IDLE
//   CLEAR  : 1 cycle; acc[*]<=0; i<=0; w_base latched.
//   FETCH_X: 1 cycle; in_addr=i.
//   MAC    : NUM_OUTPUTS+1 cycles, k=0..NUM_OUTPUTS. k=0 latches x<=in_data.
//            For k<NUM_OUTPUTS: w_addr=w_base+i*NUM_OUTPUTS+k.
//            For k>=1: acc[k-1] += (x*w_data)>>>FRAC_W.
//            After k=NUM_OUTPUTS: i==NUM_INPUTS-1 -> BIAS; else i++, FETCH_X.
//   BIAS   : NUM_OUTPUTS+1 cycles. w_addr=w_base+NUM_INPUTS*NUM_OUTPUTS+k.
//            acc[k-1] += sign_ext(w_data). y_out is loaded on the exit edge.
//   DONE   : done=1; stays until start==0.
//  Latency: with start first sampled on edge 0, done rises after edge
//   NUM_INPUTS*(NUM_OUTPUTS+2)+NUM_OUTPUTS+2.
//  Address outputs are 0 in IDLE/CLEAR/DONE and hold their last value in other cycles.
//   w_addr arithmetic wraps modulo 2^W_ADDR_W.
//  Arithmetic: full 2*DATA_W signed product, then arithmetic shift right FRAC_W, then
//   sign-extend/truncate to ACC_W. Each add saturates to ACC_W min/max (no wrap).
//   y[o] = acc[o] saturated to the signed DATA_W range.
//  Handshake: start is ignored while busy; dropping start mid-run does not abort.
//   start held high after done keeps DONE (no auto-restart).
//   A new run needs start low for >=1 cycle, then high.
//  y_out holds the previous result throughout a new run; it changes only on the BIAS->DONE edge.
//  Reset mid-run: immediate return to reset state on the next edge. y_out is cleared.
//  NUM_INPUTS==1 and NUM_OUTPUTS==1 are legal; the FSM has no zero-length states.
// CONFIGURATION
//  FC_LAYER_RELU_EN defined  : y[o] = 0 when saturated acc[o] < 0 (ReLU), else as above.
//  FC_LAYER_RELU_EN undefined: y[o] is the signed saturated value (linear output layer).
//  Internal acc[*] is identical in both builds.
// TESTING (NUM_INPUTS=2, NUM_OUTPUTS=3, DATA_W=16, FRAC_W=8, ACC_W=24 unless noted)
//  1. x={1.0,2.0}, W=all 0.5, b={0,1.0,-1.0}, w_base=0
//     -> y={1.5,2.5,0.5} (0x180,0x280,0x080); done high after edge 15.
//  2. Address trace, w_base=100
//     -> MAC w_addr 100,101,102 then 103,104,105; BIAS 106,107,108; in_addr 0,1.
//  3. b={-4.0,...}, W=0, with and without FC_LAYER_RELU_EN
//     -> y[0]=0x0000 with ReLU, 0xFC00 without.
//  4. x=127.0, W=127.0 (0x7F00), NUM_INPUTS=20
//     -> acc clamps at 0x7FFFFF; y=0x7FFF, no wrap.
//  5. Two back-to-back runs with start held high through DONE
//     -> second run starts only after start low 1 cycle; y_out stable between runs.
//  6. reset asserted mid-MAC of run 1
//     -> next cycle IDLE, y_out=0, done=0; the following run gives the test-1 result exactly.

Source files
------------

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully-connected layer, y[o] = act(sum_i x[i]*W[i][o] + b[o]).
// One multiply-accumulate per cycle. x comes from an activation RAM and W/b from a
// weight ROM, both with one cycle of read latency. The block is chained to its
// neighbours with a 4-phase start/done handshake.
//
// Handshake: a run is accepted when start_i is high in IDLE. start_i is ignored
// while busy_o is high. done_o stays high until start_i is seen low, so a new run
// needs start_i low for at least one cycle and then high again.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   start_i      level run request
//   w_base_i     ROM base address of this layer, sampled when a run is accepted
//   in_addr_o    activation RAM read address; in_data_i returns one cycle later
//   w_addr_o     weight ROM read address; w_data_i returns one cycle later
//   busy_o       high in every state except IDLE and DONE
//   done_o       high in DONE
//   y_out_o      y[o] at bits [o*DATA_W +: DATA_W], updated only when a run completes
//   state_o      current FSM state (debug)
//
// Build option: define FC_LAYER_RELU_EN to clamp negative outputs to zero (ReLU).
// Without it the outputs are the signed saturated sums (linear layer).
module fc_layer_seq #(
    parameter int NUM_INPUTS  = 20,
    parameter int NUM_OUTPUTS = 7,
    parameter int DATA_W      = 32,
    parameter int FRAC_W      = 16,
    parameter int ACC_W       = 40,
    parameter int IN_ADDR_W   = 5,
    parameter int W_ADDR_W    = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic [W_ADDR_W-1:0]           w_base_i,
    output logic [IN_ADDR_W-1:0]          in_addr_o,
    input  logic [DATA_W-1:0]             in_data_i,
    output logic [W_ADDR_W-1:0]           w_addr_o,
    input  logic [DATA_W-1:0]             w_data_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [NUM_OUTPUTS*DATA_W-1:0] y_out_o,
    output logic [2:0]                    state_o
);

    localparam int I_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int K_W   = $clog2(NUM_OUTPUTS + 1);
    localparam int EXT_W = (2 * DATA_W > ACC_W) ? 2 * DATA_W : ACC_W;

    localparam logic [I_W-1:0] I_LAST = I_W'(NUM_INPUTS - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_OUTPUTS);

    localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam logic signed [DATA_W-1:0] D_MAX   = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN   = {1'b1, {(DATA_W - 1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  Y_MAX   = ACC_W'(D_MAX);
    localparam logic signed [ACC_W-1:0]  Y_MIN   = ACC_W'(D_MIN);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH_X, S_MAC, S_BIAS, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [I_W-1:0]            i_q, i_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [DATA_W-1:0]         x_q, x_d;
    logic [W_ADDR_W-1:0]       base_q, base_d;
    logic signed [ACC_W-1:0]   acc_q [NUM_OUTPUTS];
    logic signed [ACC_W-1:0]   acc_d [NUM_OUTPUTS];
    logic [NUM_OUTPUTS*DATA_W-1:0] y_q, y_d;
    // Address holding registers: addresses keep their last value in cycles
    // where no new read is issued.
    logic [IN_ADDR_W-1:0]      in_addr_q, in_addr_d;
    logic [W_ADDR_W-1:0]       w_addr_q, w_addr_d;

    logic                      acc_en;
    logic                      y_load;
    logic signed [ACC_W-1:0]   addend;

    // Datapath terms: full-width product, arithmetic shift back to the Q format,
    // then sign-extend or truncate to the accumulator width.
    logic signed [2*DATA_W-1:0] prod;
    logic signed [EXT_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    prod_term;
    logic signed [ACC_W-1:0]    bias_term;
    logic [W_ADDR_W-1:0]        mac_addr;
    logic [W_ADDR_W-1:0]        bias_addr;

    assign prod      = $signed(x_q) * $signed(w_data_i);
    assign prod_ext  = EXT_W'(prod);
    assign prod_term = ACC_W'(prod_ext >>> FRAC_W);
    assign bias_term = ACC_W'($signed(w_data_i));

    // Weights are stored row-major by input; biases follow the last row.
    // Both sums wrap modulo 2^W_ADDR_W.
    assign mac_addr  = base_q + W_ADDR_W'(i_q) * W_ADDR_W'(NUM_OUTPUTS) + W_ADDR_W'(k_q);
    assign bias_addr = base_q + W_ADDR_W'(NUM_INPUTS * NUM_OUTPUTS) + W_ADDR_W'(k_q);

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // The two top bits disagree only on signed overflow; the top bit gives the direction.
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

    function automatic logic [DATA_W-1:0] to_y(input logic signed [ACC_W-1:0] a);
        logic [DATA_W-1:0] r;
        if (a > Y_MAX) begin
            r = D_MAX;
        end else if (a < Y_MIN) begin
            r = D_MIN;
        end else begin
            r = a[DATA_W-1:0];
        end
`ifdef FC_LAYER_RELU_EN
        if (a[ACC_W-1]) begin
            r = '0;
        end
`endif
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        k_d       = k_q;
        x_d       = x_q;
        base_d    = base_q;
        y_d       = y_q;
        in_addr_d = in_addr_q;
        w_addr_d  = w_addr_q;
        acc_en    = 1'b0;
        y_load    = 1'b0;
        addend    = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            acc_d[o] = acc_q[o];
        end

        case (state_q)
            S_IDLE: begin
                in_addr_d = '0;
                w_addr_d  = '0;
                if (start_i) begin
                    state_d = S_CLEAR;
                    base_d  = w_base_i;
                end
            end
            S_CLEAR: begin
                in_addr_d = '0;
                w_addr_d  = '0;
                i_d       = '0;
                k_d       = '0;
                for (int o = 0; o < NUM_OUTPUTS; o++) begin
                    acc_d[o] = '0;
                end
                state_d = S_FETCH_X;
            end
            S_FETCH_X: begin
                in_addr_d = IN_ADDR_W'(i_q);
                k_d       = '0;
                state_d   = S_MAC;
            end
            S_MAC: begin
                // k=0 captures x; each later step consumes the weight addressed one cycle earlier.
                if (k_q == '0) begin
                    x_d = in_data_i;
                end else begin
                    acc_en = 1'b1;
                    addend = prod_term;
                end
                if (k_q != K_LAST) begin
                    w_addr_d = mac_addr;
                    k_d      = k_q + 1'b1;
                end else begin
                    k_d = '0;
                    if (i_q == I_LAST) begin
                        state_d = S_BIAS;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = S_FETCH_X;
                    end
                end
            end
            S_BIAS: begin
                if (k_q != '0) begin
                    acc_en = 1'b1;
                    addend = bias_term;
                end
                if (k_q != K_LAST) begin
                    w_addr_d = bias_addr;
                    k_d      = k_q + 1'b1;
                end else begin
                    k_d     = '0;
                    y_load  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                in_addr_d = '0;
                w_addr_d  = '0;
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (acc_en) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                if (k_q == K_W'(o + 1)) begin
                    acc_d[o] = sat_add(acc_q[o], addend);
                end
            end
        end

        // Outputs are taken from the post-update accumulators so the last bias add is included.
        if (y_load) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                y_d[o*DATA_W +: DATA_W] = to_y(acc_d[o]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            k_q       <= '0;
            x_q       <= '0;
            base_q    <= '0;
            y_q       <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                acc_q[o] <= '0;
            end
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            k_q       <= k_d;
            x_q       <= x_d;
            base_q    <= base_d;
            y_q       <= y_d;
            in_addr_q <= in_addr_d;
            w_addr_q  <= w_addr_d;
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                acc_q[o] <= acc_d[o];
            end
        end
    end

    assign in_addr_o = in_addr_d;
    assign w_addr_o  = w_addr_d;
    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign y_out_o   = y_q;
    assign state_o   = state_q;

endmodule
